// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// k_and_s_pkg / datapath
//
// Execution datapath of the K&S 16-bit core. It holds the PC, the IR, a 4x16
// register file, the ALU and the flags register. The control unit drives the
// strobes and selects below and receives the decoded instruction and the
// registered flags in return.
//
// Ports:
//   clk                  rising-edge clock for all state
//   rst_n                synchronous active-low reset, overrides every strobe
//   branch               PC update source: 1 = IR target, 0 = PC+1
//   pc_enable            PC update strobe
//   ir_enable            IR <= data_in
//   write_reg_enable     register-file write strobe
//   addr_sel             ram_addr source: 1 = PC, 0 = IR operand field
//   c_sel                1 = ALU result to R[IR[5:4]], 0 = data_in to R[IR[6:5]]
//   operation            ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//   flags_reg_enable     flags register load strobe
//   decoded_instruction  combinational decode of IR[15:8]
//   zero_op, neg_op,
//   unsigned_overflow,
//   signed_overflow      registered ALU flags
//   ram_addr             RAM word address
//   data_out             RAM write data = R[IR[6:5]]
//   data_in              RAM read data
// ---------------------------------------------------------------------------
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BNZERO, I_BNNEG,
        I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
    } decoded_instruction_type;
endpackage

module datapath
    import k_and_s_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int RESET_PC   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [15:0]             data_out,
    input  logic [15:0]             data_in
);

    logic [ADDR_WIDTH-1:0] pc;
    logic [15:0]           ir;
    logic [15:0]           regs [4];

    logic [1:0]  a_sel, b_sel, c_dest, mem_reg, wr_dest;
    logic [15:0] a_val, b_val, wr_data;
    logic [16:0] alu_res;
    logic        alu_sovf;

    // IR[7] carries no field for any instruction.
    logic unused_ir_bit;
    assign unused_ir_bit = ir[7];

    // ---------------- decode ----------------
    always_comb begin
        // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
        decoded_instruction = I_NOP;
        unique case (ir[15:8])
            8'h01:   decoded_instruction = I_BRANCH;
            8'h02:   decoded_instruction = I_BZERO;
            8'h03:   decoded_instruction = I_BNEG;
            8'h05:   decoded_instruction = I_BNZERO;
            8'h04:   decoded_instruction = I_BNNEG;
            8'h81:   decoded_instruction = I_LOAD;
            8'h82:   decoded_instruction = I_STORE;
            8'h91:   decoded_instruction = I_MOVE;
            8'hA1:   decoded_instruction = I_ADD;
            8'hA2:   decoded_instruction = I_SUB;
            8'hA3:   decoded_instruction = I_AND;
            8'hA4:   decoded_instruction = I_OR;
            8'hFF:   decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    // ---------------- register file reads ----------------
    assign c_dest  = ir[5:4];
    assign a_sel   = ir[3:2];
    // MOVE is issued as OR with b forced to a, so the result is R[a].
    assign b_sel   = (decoded_instruction == I_MOVE) ? ir[3:2] : ir[1:0];
    assign mem_reg = ir[6:5];

    assign a_val    = regs[a_sel];
    assign b_val    = regs[b_sel];
    assign data_out = regs[mem_reg];

    assign ram_addr = addr_sel ? pc : ir[ADDR_WIDTH-1:0];

    // ---------------- ALU ----------------
    // Operands are zero-extended to 17 bits: bit 16 is the ADD carry-out and,
    // for SUB, the borrow (set exactly when a < b unsigned).
    always_comb begin
        alu_res  = '0;
        alu_sovf = 1'b0;
        unique case (operation)
            2'b00: alu_res = {1'b0, a_val | b_val};
            2'b01: begin
                alu_res  = {1'b0, a_val} + {1'b0, b_val};
                alu_sovf = (a_val[15] == b_val[15]) && (alu_res[15] != a_val[15]);
            end
            2'b10: begin
                alu_res  = {1'b0, a_val} - {1'b0, b_val};
                alu_sovf = (a_val[15] != b_val[15]) && (alu_res[15] != a_val[15]);
            end
            2'b11: alu_res = {1'b0, a_val & b_val};
            default: alu_res = '0;
        endcase
    end

    assign wr_dest = c_sel ? c_dest : mem_reg;
    assign wr_data = c_sel ? alu_res[15:0] : data_in;

    // ---------------- state ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc                <= ADDR_WIDTH'(RESET_PC);
            ir                <= '0;
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
            // NOTE: the register file is small flops, not a RAM macro, so it is reset to a known zero.
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if (pc_enable)
                pc <= branch ? ir[ADDR_WIDTH-1:0] : pc + 1'b1;
            if (ir_enable)
                ir <= data_in;
            if (write_reg_enable)
                regs[wr_dest] <= wr_data;
            if (flags_reg_enable) begin
                zero_op           <= (alu_res[15:0] == 16'h0000);
                neg_op            <= alu_res[15];
                unsigned_overflow <= alu_res[16];
                signed_overflow   <= alu_sovf;
            end
        end
    end

endmodule

// File: tb/tb_datapath.sv
// ---------------------------------------------------------------------------
// tb_datapath
//
// Scoreboard bench for datapath. Stimulus drives directed vectors and pushes
// the hand-computed expected observations into a queue; a monitor process
// pops and compares them on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_datapath;
    import k_and_s_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    branch, pc_enable, ir_enable, write_reg_enable;
    logic                    addr_sel, c_sel, flags_reg_enable;
    logic [1:0]              operation;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [4:0]              ram_addr;
    logic [15:0]             data_out, data_in;

    datapath #(.ADDR_WIDTH(5), .RESET_PC(0)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .write_reg_enable    (write_reg_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .flags_reg_enable    (flags_reg_enable),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_out            (data_out),
        .data_in             (data_in)
    );

    always #5 clk = ~clk;

    typedef enum {K_ZERO, K_NEG, K_UOVF, K_SOVF, K_ADDR, K_DOUT, K_DEC} kind_t;
    typedef struct {
        kind_t       kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ---------------- monitor ----------------
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.kind)
                    K_ZERO:  act = {15'd0, zero_op};
                    K_NEG:   act = {15'd0, neg_op};
                    K_UOVF:  act = {15'd0, unsigned_overflow};
                    K_SOVF:  act = {15'd0, signed_overflow};
                    K_ADDR:  act = {11'd0, ram_addr};
                    K_DOUT:  act = data_out;
                    default: act = 16'(decoded_instruction);
                endcase
                n_checks++;
                if (act === e.val) n_pass++;
                else $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic expect_obs(input kind_t k, input logic [15:0] v, input string name);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_flags(input logic z, input logic n, input logic u, input logic s,
                                input string tag);
        expect_obs(K_ZERO, {15'd0, z}, {tag, "_zero"});
        expect_obs(K_NEG,  {15'd0, n}, {tag, "_neg"});
        expect_obs(K_UOVF, {15'd0, u}, {tag, "_uovf"});
        expect_obs(K_SOVF, {15'd0, s}, {tag, "_sovf"});
    endtask

    // Let the monitor consume everything queued; a stuck queue is a failure.
    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic idle();
        branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
        c_sel = 0; flags_reg_enable = 0; operation = 2'b00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [15:0] v);
        data_in = v; ir_enable = 1;
        step();
        ir_enable = 0;
    endtask

    // LOAD Rr from data_in
    task automatic load_reg(input logic [1:0] r, input logic [15:0] v);
        set_ir({8'h81, 1'b0, r, 5'd1});
        data_in = v; c_sel = 0; write_reg_enable = 1;
        step();
        write_reg_enable = 0;
    endtask

    // Observe Rr through data_out with a STORE in IR
    task automatic check_reg(input logic [1:0] r, input logic [15:0] v, input string name);
        set_ir({8'h82, 1'b0, r, 5'd2});
        expect_obs(K_DOUT, v, name);
        drain();
    endtask

    task automatic alu_op(input logic [15:0] instr, input logic [1:0] op, input logic flags);
        set_ir(instr);
        operation = op; c_sel = 1; write_reg_enable = 1; flags_reg_enable = flags;
        step();
        idle();
    endtask

    // ---------------- stimulus ----------------
    typedef struct { logic [15:0] ir; decoded_instruction_type d; } dec_vec_t;
    dec_vec_t dec_tab[6];

    initial begin
        dec_tab[0] = '{16'h7700, I_NOP};
        dec_tab[1] = '{16'hFF00, I_HALT};
        dec_tab[2] = '{16'h0500, I_BNZERO};
        dec_tab[3] = '{16'h0400, I_BNNEG};
        dec_tab[4] = '{16'hA400, I_OR};
        dec_tab[5] = '{16'h0100, I_BRANCH};

        idle();
        addr_sel = 0; data_in = 16'h0; rst_n = 0;
        step(); step();
        rst_n = 1;

        // 1: reset state
        set_ir(16'h0000);
        addr_sel = 1;
        expect_obs(K_ADDR, 16'd0, "reset_pc");
        expect_flags(0, 0, 0, 0, "reset");
        expect_obs(K_DEC, 16'(I_NOP), "reset_dec");
        drain();
        addr_sel = 0;
        expect_obs(K_ADDR, 16'd0, "reset_ram_addr_ir");
        drain();

        // 2: 7FFF + 1 into R1
        load_reg(1, 16'h7FFF);
        load_reg(2, 16'h0001);
        alu_op(16'hA116, 2'b01, 1);
        expect_obs(K_DEC, 16'(I_ADD), "add_dec");
        expect_flags(0, 1, 0, 1, "add");
        drain();
        check_reg(1, 16'h8000, "add_r1");

        // 3: 3 - 5 into R0, then R0 & R3(=0)
        load_reg(1, 16'h0003);
        load_reg(2, 16'h0005);
        alu_op(16'hA206, 2'b10, 1);
        expect_flags(0, 1, 1, 0, "sub");
        drain();
        check_reg(0, 16'hFFFE, "sub_r0");
        alu_op(16'hA303, 2'b11, 1);
        expect_flags(1, 0, 0, 0, "and");
        drain();
        check_reg(0, 16'h0000, "and_r0");

        // flags hold without strobe: R1 = 3 + 5 written, flags untouched
        alu_op(16'hA116, 2'b01, 0);
        expect_flags(1, 0, 0, 0, "hold");
        drain();
        check_reg(1, 16'h0008, "hold_r1");

        // MOVE R3 <- R1 with b field pointing at a non-zero R0
        load_reg(0, 16'h0F00);
        alu_op(16'h9134, 2'b00, 0);
        check_reg(3, 16'h0008, "move_r3");

        // 4: PC wrap and branching
        set_ir(16'h021F);
        expect_obs(K_DEC, 16'(I_BZERO), "bzero_dec");
        drain();
        branch = 1; pc_enable = 1; step(); idle();
        addr_sel = 1;
        expect_obs(K_ADDR, 16'd31, "pc_31");
        drain();
        pc_enable = 1; step(); idle();
        expect_obs(K_ADDR, 16'd0, "pc_wrap");
        drain();
        set_ir(16'h0207);
        branch = 1; pc_enable = 1; step(); idle();
        expect_obs(K_ADDR, 16'd7, "pc_branch");
        drain();
        branch = 1; step(); idle();
        expect_obs(K_ADDR, 16'd7, "pc_branch_no_enable");
        drain();
        // simultaneous IR load and PC increment
        data_in = 16'h0305; ir_enable = 1; pc_enable = 1; step(); idle();
        expect_obs(K_ADDR, 16'd8, "pc_with_ir");
        expect_obs(K_DEC, 16'(I_BNEG), "ir_with_pc");
        drain();
        branch = 1; pc_enable = 1; step(); idle();
        expect_obs(K_ADDR, 16'd5, "pc_new_target");
        drain();

        // 5: LOAD R3,5 then STORE R3
        addr_sel = 0;
        set_ir(16'h8165);
        expect_obs(K_ADDR, 16'd5, "load_addr");
        expect_obs(K_DEC, 16'(I_LOAD), "load_dec");
        drain();
        data_in = 16'hABCD; c_sel = 0; write_reg_enable = 1; step(); idle();
        set_ir(16'h8265);
        expect_obs(K_DOUT, 16'hABCD, "store_data");
        expect_obs(K_DEC, 16'(I_STORE), "store_dec");
        drain();

        // 6: random strobes, reset asserted with strobes still active
        for (int i = 0; i < 8; i++) begin
            {branch, pc_enable, ir_enable, write_reg_enable, c_sel, flags_reg_enable} = 6'($urandom);
            operation = 2'($urandom);
            data_in   = 16'($urandom);
            if (i == 6) rst_n = 0;
            step();
        end
        rst_n = 1;
        idle();
        addr_sel = 1;
        expect_obs(K_ADDR, 16'd0, "rst_pc");
        expect_obs(K_DEC, 16'(I_NOP), "rst_dec");
        expect_obs(K_DOUT, 16'h0000, "rst_r0");
        expect_flags(0, 0, 0, 0, "rst");
        drain();
        check_reg(1, 16'h0000, "rst_r1");
        check_reg(2, 16'h0000, "rst_r2");
        check_reg(3, 16'h0000, "rst_r3");

        for (int i = 0; i < 6; i++) begin
            set_ir(dec_tab[i].ir);
            expect_obs(K_DEC, 16'(dec_tab[i].d), $sformatf("dec_%h", dec_tab[i].ir));
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
